// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the three buses that meet at the memory arbiter:
//     icache side : iREN, iaddr (to arbiter); iwait, iload (from arbiter)
//     dcache side : dREN, dWEN, daddr, dstore (to arbiter); dwait, dload (from arbiter)
//     RAM side    : ramREN, ramWEN, ramaddr, ramstore (from arbiter); ramload, ramstate (to arbiter)
//   Modports:
//     slave  - the arbiter's view (serves the caches, drives the RAM)
//     master - the surrounding environment's view (caches + RAM)
interface mem_arbiter_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port RAM between the icache miss port and the dcache.
//   A grant is held for a whole RAM transaction. The dcache normally wins,
//   but after STARVE_LIMIT dcache grants made while the icache was waiting,
//   the icache is forced ahead. Every completion is followed by one IDLE
//   cycle before the next grant.
//   Ports:
//     CLK   - clock, rising edge
//     nRST  - asynchronous active-low reset
//     bus   - mem_arbiter_if.slave (icache, dcache and RAM buses)
//   Parameters:
//     WORD_W, ADDR_W - data / address widths (must match the interface)
//     STARVE_LIMIT   - dcache grants tolerated while iREN pends (>=1)
module mem_arbiter #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic           CLK,
    input logic           nRST,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;

    logic dreq;
    logic ram_done;

    assign dreq     = bus.dREN | bus.dWEN;
    assign ram_done = (bus.ramstate == RAM_ACCESS);

    // Grant decision and transaction tracking. A granted requester that
    // withdraws before ACCESS aborts back to IDLE without a wait pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && bus.iREN && starve_cnt == LIMIT) begin
                        state <= IGRANT;
                    end else if (dreq) begin
                        state <= DGRANT;
                        if (bus.iREN && starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (bus.iREN) begin
                        state <= IGRANT;
                    end
                end
                IGRANT: begin
                    if (!bus.iREN) begin
                        state <= IDLE;
                    end else if (ram_done) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end
                end
                DGRANT: begin
                    if (!dreq || ram_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic              iwait_c, dwait_c, ramren_c, ramwen_c;
    logic [WORD_W-1:0] iload_c, dload_c, ramstore_c;
    logic [ADDR_W-1:0] ramaddr_c;

    // RAM controls and completion strobes follow the live request in the
    // granted state so a 0-wait RAM completes in the grant cycle itself.
    always_comb begin
        iwait_c    = 1'b1;
        dwait_c    = 1'b1;
        iload_c    = '0;
        dload_c    = '0;
        ramren_c   = 1'b0;
        ramwen_c   = 1'b0;
        ramaddr_c  = '0;
        ramstore_c = '0;
        case (state)
            IGRANT: begin
                ramren_c  = bus.iREN;
                ramaddr_c = bus.iaddr;
                if (bus.iREN && ram_done) begin
                    iwait_c = 1'b0;
                    iload_c = bus.ramload;
                end
            end
            DGRANT: begin
                ramwen_c   = bus.dWEN;
                ramren_c   = bus.dREN & ~bus.dWEN;
                ramaddr_c  = bus.daddr;
                ramstore_c = bus.dstore;
                if (dreq && ram_done) begin
                    dwait_c = 1'b0;
                    if (!bus.dWEN)
                        dload_c = bus.ramload;
                end
            end
            default: ;
        endcase
    end

    assign bus.iwait    = iwait_c;
    assign bus.iload    = iload_c;
    assign bus.dwait    = dwait_c;
    assign bus.dload    = dload_c;
    assign bus.ramREN   = ramren_c;
    assign bus.ramWEN   = ramwen_c;
    assign bus.ramaddr  = ramaddr_c;
    assign bus.ramstore = ramstore_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: a directed vector table, hand-written
//   starvation and reset sequences, then randomized traffic against a
//   behavioural model of the arbitration rules.
module tb_mem_arbiter;
    localparam int LIMIT = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
    localparam logic [31:0] IA = 32'h40, DA = 32'h80, DS = 32'h12345678, RL = 32'hDEADBEEF;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.WORD_W(32), .ADDR_W(32)) bus ();

    mem_arbiter #(.WORD_W(32), .ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        i, d, w;
        logic [1:0]  rs;
        logic        rren, rwen;
        logic [31:0] addr, store;
        logic        iw, dw;
        logic [31:0] il, dl;
    } vec_t;

    function automatic vec_t mk(input logic i, d, w, input logic [1:0] rs,
                                input logic rren, rwen, input logic [31:0] addr, store,
                                input logic iw, dw, input logic [31:0] il, dl);
        vec_t v;
        v.i = i; v.d = d; v.w = w; v.rs = rs;
        v.rren = rren; v.rwen = rwen; v.addr = addr; v.store = store;
        v.iw = iw; v.dw = dw; v.il = il; v.dl = dl;
        return v;
    endfunction

    function automatic vec_t idle_row(input logic i, d, w, input logic [1:0] rs);
        return mk(i, d, w, rs, 0, 0, 0, 0, 1, 1, 0, 0);
    endfunction

    vec_t tbl[24];

    task automatic set_inputs(input logic i, d, w, input logic [1:0] rs);
        bus.iREN = i; bus.dREN = d; bus.dWEN = w; bus.ramstate = rs;
    endtask

    task automatic check_outputs(input string tag, input logic rren, rwen,
                                 input logic [31:0] addr, store,
                                 input logic iw, dw, input logic [31:0] il, dl);
        check({tag, ".ramREN"},   32'(bus.ramREN), 32'(rren));
        check({tag, ".ramWEN"},   32'(bus.ramWEN), 32'(rwen));
        check({tag, ".ramaddr"},  bus.ramaddr, addr);
        check({tag, ".ramstore"}, bus.ramstore, store);
        check({tag, ".iwait"},    32'(bus.iwait), 32'(iw));
        check({tag, ".dwait"},    32'(bus.dwait), 32'(dw));
        check({tag, ".iload"},    bus.iload, il);
        check({tag, ".dload"},    bus.dload, dl);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        set_inputs(0, 0, 0, FREE);
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    // Behavioural model: who owns the RAM, and how many dcache wins have
    // piled up while the icache waited.
    typedef enum int {M_NONE, M_ICACHE, M_DCACHE} owner_t;
    owner_t m_owner;
    int     m_dwins;

    task automatic model_check(input string tag);
        logic        dreq, done;
        logic        rren, rwen, iw, dw;
        logic [31:0] addr, store, il, dl;
        dreq = bus.dREN | bus.dWEN;
        done = (bus.ramstate == ACC);
        rren = 0; rwen = 0; iw = 1; dw = 1; addr = 0; store = 0; il = 0; dl = 0;
        if (m_owner == M_ICACHE) begin
            rren = bus.iREN;
            addr = bus.iaddr;
            if (bus.iREN && done) begin iw = 0; il = bus.ramload; end
        end else if (m_owner == M_DCACHE) begin
            rwen  = bus.dWEN;
            rren  = bus.dREN && !bus.dWEN;
            addr  = bus.daddr;
            store = bus.dstore;
            if (dreq && done) begin dw = 0; dl = bus.dWEN ? 32'h0 : bus.ramload; end
        end
        check_outputs(tag, rren, rwen, addr, store, iw, dw, il, dl);
    endtask

    task automatic model_advance();
        logic dreq, done;
        dreq = bus.dREN | bus.dWEN;
        done = (bus.ramstate == ACC);
        case (m_owner)
            M_NONE: begin
                if (dreq && bus.iREN && m_dwins >= LIMIT) m_owner = M_ICACHE;
                else if (dreq) begin
                    m_owner = M_DCACHE;
                    if (bus.iREN) m_dwins = (m_dwins + 1 > LIMIT) ? LIMIT : m_dwins + 1;
                end else if (bus.iREN) m_owner = M_ICACHE;
            end
            M_ICACHE: begin
                if (!bus.iREN) m_owner = M_NONE;
                else if (done) begin m_owner = M_NONE; m_dwins = 0; end
            end
            default: if (!dreq || done) m_owner = M_NONE;
        endcase
    endtask

    initial begin
        byte got[$];
        byte exp_seq[6];
        int  k;

        bus.iaddr = IA; bus.daddr = DA; bus.dstore = DS; bus.ramload = RL;
        set_inputs(1, 1, 0, ACC);
        #3;
        check_outputs("reset", 0, 0, 0, 0, 1, 1, 0, 0);

        tbl[0]  = idle_row(0, 0, 0, FREE);
        tbl[1]  = idle_row(1, 0, 0, FREE);
        tbl[2]  = mk(1, 0, 0, BUSY, 1, 0, IA, 0, 1, 1, 0, 0);
        tbl[3]  = mk(1, 0, 0, BUSY, 1, 0, IA, 0, 1, 1, 0, 0);
        tbl[4]  = mk(1, 0, 0, ACC,  1, 0, IA, 0, 0, 1, RL, 0);
        tbl[5]  = idle_row(0, 0, 0, FREE);
        tbl[6]  = idle_row(0, 0, 1, FREE);
        tbl[7]  = mk(0, 0, 1, ACC,  0, 1, DA, DS, 1, 0, 0, 0);
        tbl[8]  = idle_row(0, 0, 0, FREE);
        tbl[9]  = idle_row(1, 1, 0, FREE);
        tbl[10] = mk(1, 1, 0, ACC,  1, 0, DA, DS, 1, 0, 0, RL);
        tbl[11] = idle_row(1, 0, 0, FREE);
        tbl[12] = mk(1, 0, 0, ACC,  1, 0, IA, 0, 0, 1, RL, 0);
        tbl[13] = idle_row(1, 0, 0, FREE);
        tbl[14] = mk(1, 0, 0, BUSY, 1, 0, IA, 0, 1, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, BUSY, 0, 0, IA, 0, 1, 1, 0, 0);
        tbl[16] = idle_row(0, 0, 0, BUSY);
        tbl[17] = idle_row(0, 1, 0, FREE);
        tbl[18] = mk(0, 1, 0, ERR,  1, 0, DA, DS, 1, 1, 0, 0);
        tbl[19] = mk(0, 1, 0, ACC,  1, 0, DA, DS, 1, 0, 0, RL);
        tbl[20] = idle_row(0, 0, 0, FREE);
        tbl[21] = idle_row(0, 1, 1, FREE);
        tbl[22] = mk(0, 1, 1, ACC,  0, 1, DA, DS, 1, 0, 0, 0);
        tbl[23] = idle_row(0, 0, 0, FREE);

        do_reset();
        for (int r = 0; r < 24; r++) begin
            set_inputs(tbl[r].i, tbl[r].d, tbl[r].w, tbl[r].rs);
            @(negedge CLK);
            check_outputs($sformatf("vec%0d", r), tbl[r].rren, tbl[r].rwen, tbl[r].addr,
                          tbl[r].store, tbl[r].iw, tbl[r].dw, tbl[r].il, tbl[r].dl);
            next_cycle();
        end

        // Starvation: both sides request continuously on a 0-wait RAM.
        do_reset();
        exp_seq = '{"D", "D", "D", "D", "I", "D"};
        set_inputs(1, 1, 0, ACC);
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (!bus.dwait) got.push_back("D");
            if (!bus.iwait) got.push_back("I");
            next_cycle();
        end
        check("starve.count", 32'(got.size()), 32'd6);
        k = (got.size() < 6) ? got.size() : 6;
        for (int g = 0; g < k; g++)
            check($sformatf("starve.grant%0d", g), 32'(got[g]), 32'(exp_seq[g]));

        // Reset during a pending dcache write.
        do_reset();
        set_inputs(0, 0, 1, BUSY);
        next_cycle();
        @(negedge CLK);
        check("rst6.ramWEN_before", 32'(bus.ramWEN), 32'd1);
        #1 nRST = 1'b0;
        #1;
        check("rst6.ramWEN_async", 32'(bus.ramWEN), 32'd0);
        check("rst6.ramaddr_async", bus.ramaddr, 32'd0);
        next_cycle();
        nRST = 1'b1;
        set_inputs(0, 0, 1, ACC);
        @(negedge CLK);
        check("rst6.dwait_after", 32'(bus.dwait), 32'd1);
        check("rst6.ramWEN_idle", 32'(bus.ramWEN), 32'd0);
        next_cycle();
        @(negedge CLK);
        check("rst6.dwait_regrant", 32'(bus.dwait), 32'd0);
        next_cycle();

        // Randomized traffic against the model.
        do_reset();
        m_owner = M_NONE;
        m_dwins = 0;
        for (int c = 0; c < 4000; c++) begin
            logic i, d, w;
            int   kind;
            logic [1:0] rs;
            i = bus.iREN ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
            if (bus.dREN | bus.dWEN) begin
                d = bus.dREN; w = bus.dWEN;
                if ($urandom_range(0, 15) == 0) begin d = 0; w = 0; end
            end else begin
                kind = $urandom_range(0, 9);
                d = (kind == 1 || kind == 2 || kind == 9);
                w = (kind == 3 || kind == 4 || kind == 9);
            end
            kind = $urandom_range(0, 9);
            rs = (kind < 4) ? ACC : (kind < 7) ? BUSY : (kind < 9) ? FREE : ERR;
            bus.iaddr = $urandom; bus.daddr = $urandom;
            bus.dstore = $urandom; bus.ramload = $urandom;
            set_inputs(i, d, w, rs);
            @(negedge CLK);
            model_check($sformatf("rand%0d", c));
            model_advance();
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
